// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package kp_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } kp_state_e;

  // Row lines with no key pressed (all pulled high).
  localparam logic [3:0] KPR_IDLE = 4'hF;

  // Active-low, one-cold column drive for column index 0..3.
  localparam logic [3:0] COL_DRIVE [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Map a synchronized row pattern to {valid, row index}. A pattern is a
  // valid key only when exactly one row line is low.
  function automatic logic [2:0] row_decode(input logic [3:0] pat);
    logic [2:0] res;
    res = 3'b000;
    case (pat)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/kpscan_if.sv
// Key event channel between the scanner and the consumer of key events.
//
// Handshake: key_valid/key_code are held stable by the producer until a
// cycle where key_valid && key_ready; the event is consumed at that clock
// edge. key_ready while key_valid is low has no effect. key_held and
// overrun are status levels outside the handshake.
interface kpscan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/kpscan_tick.sv
// Free-running prescaler: one-cycle tick every DIV clock cycles.
module kpscan_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap on the tick cycle.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kpscan.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, press/release
// debounce and a single-entry key event register with overrun flag.
module kpscan
  import kp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  kpr,
  output logic [3:0]  kpc,
  kpscan_if.master    kif,
  output kp_state_e   state_dbg
);

  localparam int            DW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DCNT_TGT = DW'(DEBOUNCE_CNT);
  localparam bit            FAST     = (DEBOUNCE_CNT == 1);

  logic            tick;
  logic [3:0]      kpr_meta_q;
  logic [3:0]      kpr_s_q;
  logic [2:0]      row_dec;

  kp_state_e       state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      pat_q, pat_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [DW-1:0]   dcnt_inc;
  logic [3:0]      kpc_q, kpc_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            overrun_q, overrun_d;
  logic            issue;
  logic            handshake;

  kpscan_tick #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (reset_n),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kpr_meta_q <= KPR_IDLE;
      kpr_s_q    <= KPR_IDLE;
    end else begin
      kpr_meta_q <= kpr;
      kpr_s_q    <= kpr_meta_q;
    end
  end

  assign row_dec = row_decode(kpr_s_q);

  // Scan/debounce FSM: next state, column, capture and debounce counter.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    pat_d      = pat_q;
    dcnt_d     = dcnt_q;
    key_held_d = key_held_q;
    issue      = 1'b0;
    // Saturating increment; the FSM leaves the debounce states at the
    // target so the counter never needs to go past it.
    dcnt_inc   = (dcnt_q >= DCNT_TGT) ? DCNT_TGT : dcnt_q + DW'(1);

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (row_dec[2]) begin
            pat_d  = kpr_s_q;
            dcnt_d = DW'(1);
            if (FAST) begin
              state_d    = PRESSED;
              key_held_d = 1'b1;
              issue      = 1'b1;
            end else begin
              state_d = DEB_PRESS;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEB_PRESS: begin
        if (tick) begin
          if (kpr_s_q == pat_q) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == DCNT_TGT) begin
              state_d    = PRESSED;
              key_held_d = 1'b1;
              issue      = 1'b1;
            end
          end else begin
            state_d = SCAN;
            dcnt_d  = '0;
            col_d   = col_q + 2'd1;
          end
        end
      end
      PRESSED: begin
        if (tick && (kpr_s_q == KPR_IDLE)) begin
          dcnt_d = DW'(1);
          if (FAST) begin
            state_d    = SCAN;
            key_held_d = 1'b0;
            dcnt_d     = '0;
            col_d      = col_q + 2'd1;
          end else begin
            state_d = DEB_RELEASE;
          end
        end
      end
      DEB_RELEASE: begin
        if (tick) begin
          if (kpr_s_q == KPR_IDLE) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == DCNT_TGT) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              dcnt_d     = '0;
              col_d      = col_q + 2'd1;
            end
          end else begin
            state_d = PRESSED;
          end
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    kpc_d = COL_DRIVE[col_d];
  end

  assign handshake = key_valid_q && kif.key_ready;

  // Event register: a new press loads when the slot is free or is being
  // emptied this cycle; otherwise it is dropped and flagged as overrun.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (issue) begin
      if (!key_valid_q || handshake) begin
        key_code_d  = {col_q, row_dec[1:0]};
        key_valid_d = 1'b1;
        if (handshake) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      pat_q       <= KPR_IDLE;
      dcnt_q      <= '0;
      kpc_q       <= COL_DRIVE[0];
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      dcnt_q      <= dcnt_d;
      kpc_q       <= kpc_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

  assign kpc           = kpc_q;
  assign kif.key_code  = key_code_q;
  assign kif.key_valid = key_valid_q;
  assign kif.key_held  = key_held_q;
  assign kif.overrun   = overrun_q;
  assign state_dbg     = state_q;

endmodule
